// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit 7-segment scan driver.
// Segment patterns are {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [1:0] DIG_SEC1  = 2'd0;
    localparam logic [1:0] DIG_SEC10 = 2'd1;
    localparam logic [1:0] DIG_MIN1  = 2'd2;
    localparam logic [1:0] DIG_MIN10 = 2'd3;

    function automatic logic [3:0] dig_onehot(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder.
// Codes 10..15 render as a dash so bad upstream data is visible.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit display driver with per-frame snapshot and blinking dot.
// Optional leading-zero blanking: define SEG7_LZ_BLANK_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DWELL_CYC  = 1,
    parameter int BLINK_HALF = 500
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] MIN_S10,
    input  logic [3:0] MIN_S1,
    input  logic [3:0] SEC_S10,
    input  logic [3:0] SEC_S1,
    output logic [7:0] SEG,
    output logic [3:0] COM,
    output logic       FRAME
);

    localparam int DW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYC - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    logic [DW-1:0] dwell;
    logic [1:0]    idx;
    logic [BW-1:0] blink;
    logic          dot;
    logic [15:0]   snap;
    logic          first;

    logic [15:0]   in_word;
    logic [15:0]   src_word;
    logic [3:0]    cur;
    logic [6:0]    dec;
    logic [6:0]    glyph;
    logic          dwell_wrap;
    logic          take;

    assign in_word    = {MIN_S10, MIN_S1, SEC_S10, SEC_S1};
    assign dwell_wrap = (dwell == DWELL_LAST);
    assign take       = first | (dwell_wrap & (idx == DIG_MIN10));

    // On the very first edge the snapshot register is still empty,
    // so display straight from the inputs being captured.
    assign src_word = first ? in_word : snap;
    assign cur      = src_word[{idx, 2'b00} +: 4];

    bcd_to_seg7 u_dec (
        .bcd (cur),
        .seg (dec)
    );

    always_comb begin
        glyph = dec;
`ifdef SEG7_LZ_BLANK_EN
        if (idx == DIG_MIN10 && src_word[15:12] == 4'd0)
            glyph = SEG_BLANK;
        if (idx == DIG_MIN1 && src_word[15:12] == 4'd0
            && src_word[11:8] == 4'd0)
            glyph = SEG_BLANK;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            dwell <= '0;
            idx   <= DIG_SEC1;
            first <= 1'b1;
            snap  <= '0;
        end else begin
            first <= 1'b0;
            if (dwell_wrap) begin
                dwell <= '0;
                idx   <= idx + 2'd1;
            end else begin
                dwell <= dwell + 1'b1;
            end
            if (take)
                snap <= in_word;
        end
    end

    // Free-running blink timebase, independent of the scan.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            blink <= '0;
            dot   <= 1'b0;
        end else if (blink == BLINK_LAST) begin
            blink <= '0;
            dot   <= ~dot;
        end else begin
            blink <= blink + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            SEG   <= 8'h00;
            COM   <= 4'b0000;
            FRAME <= 1'b0;
        end else begin
            SEG   <= {(idx == DIG_MIN1) & dot, glyph};
            COM   <= dig_onehot(idx);
            FRAME <= take;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver against a cycle-count based model.
// Build with SEG7_LZ_BLANK_EN to check leading-zero blanking.
module tb_seg7_scan_driver;

    localparam int DWELL_CYC  = 1;
    localparam int BLINK_HALF = 500;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [3:0] MIN_S10 = '0;
    logic [3:0] MIN_S1 = '0;
    logic [3:0] SEC_S10 = '0;
    logic [3:0] SEC_S1 = '0;
    logic [7:0] SEG;
    logic [3:0] COM;
    logic       FRAME;

    seg7_scan_driver #(
        .DWELL_CYC  (DWELL_CYC),
        .BLINK_HALF (BLINK_HALF)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .MIN_S10 (MIN_S10),
        .MIN_S1  (MIN_S1),
        .SEC_S10 (SEC_S10),
        .SEC_S1  (SEC_S1),
        .SEG     (SEG),
        .COM     (COM),
        .FRAME   (FRAME)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int passed = 0;
    int k = 0;
    int exp_dot_on = 0;
    int got_dot_on = 0;
    logic [3:0] msnap [4];
    logic [6:0] lut [16];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // k = number of clocked non-reset edges since the last reset.
    task automatic cyc();
        logic [3:0] in_d [4];
        logic [3:0] src [4];
        logic [7:0] es;
        logic [3:0] ec;
        logic       ef;
        int         id;
        in_d[0] = SEC_S1;
        in_d[1] = SEC_S10;
        in_d[2] = MIN_S1;
        in_d[3] = MIN_S10;
        es = '0;
        ec = '0;
        ef = 1'b0;
        if (RESET) begin
            k = 0;
            for (int i = 0; i < 4; i++) msnap[i] = '0;
        end else begin
            id = (k / DWELL_CYC) % 4;
            for (int i = 0; i < 4; i++)
                src[i] = (k == 0) ? in_d[i] : msnap[i];
            es[6:0] = lut[src[id]];
`ifdef SEG7_LZ_BLANK_EN
            if (id == 3 && src[3] == 0) es[6:0] = 7'h00;
            if (id == 2 && src[3] == 0 && src[2] == 0) es[6:0] = 7'h00;
`endif
            es[7] = (id == 2) && (((k / BLINK_HALF) % 2) == 1);
            ec = 4'b0001 << id;
            ef = (k == 0) || (((k + 1) % (4 * DWELL_CYC)) == 0);
            if (ef)
                for (int i = 0; i < 4; i++) msnap[i] = in_d[i];
            k++;
        end
        @(posedge CLK);
        #1;
        chk("seg", SEG, es);
        chk("com", COM, ec);
        chk("frame", FRAME, ef);
        chk("com_onehot", $countones(COM) <= 1, 1);
        chk("dot_only_dig2", SEG[7] & (COM != 4'b0100), 0);
        if (es[7]) exp_dot_on++;
        if (SEG[7] === 1'b1) got_dot_on++;
    endtask

    task automatic set_digits(input logic [3:0] m10, input logic [3:0] m1,
                              input logic [3:0] s10, input logic [3:0] s1);
        MIN_S10 = m10;
        MIN_S1  = m1;
        SEC_S10 = s10;
        SEC_S1  = s1;
    endtask

    initial begin
        logic found;
        lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

        RESET = 1'b1;
        cyc();
        cyc();
        chk("rst_seg", SEG, 8'h00);
        chk("rst_com", COM, 4'b0000);
        chk("rst_frame", FRAME, 1'b0);

        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        RESET = 1'b0;
        cyc();
        chk("first_frame", FRAME, 1'b1);
        chk("first_com", COM, 4'b0001);
        chk("first_seg", SEG[6:0], 7'h66);
        repeat (11) cyc();

        for (int i = 0; i < 4 && (k % 4) != 1; i++) cyc();
        SEC_S1 = 4'd5;
        repeat (9) cyc();

        SEC_S10 = 4'hC;
        repeat (8) cyc();

        repeat (300) begin
            set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            RESET = ($urandom_range(0, 39) == 0);
            cyc();
        end
        RESET = 1'b0;

        set_digits(4'd5, 4'd9, 4'd5, 4'd8);
        exp_dot_on = 0;
        got_dot_on = 0;
        repeat (2000) cyc();
        chk("dot_on_count", got_dot_on, exp_dot_on);

        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            cyc();
            if (COM == 4'b0100) found = 1'b1;
        end
        chk("find_com_0100", found, 1'b1);
        RESET = 1'b1;
        cyc();
        chk("midrst_seg", SEG, 8'h00);
        chk("midrst_com", COM, 4'b0000);
        RESET = 1'b0;
        cyc();
        chk("midrst_com_after", COM, 4'b0001);
        chk("midrst_frame_after", FRAME, 1'b1);

        set_digits(4'd0, 4'd0, 4'd0, 4'd7);
        repeat (1200) cyc();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream of the stopwatch core: consumes the four BCD digits (MIN_S10, MIN_S1, SEC_S10, SEC_S1) and time-multiplexes them onto one 4-digit common-cathode 7-segment display.
- Adds per-frame digit snapshot (no tearing), a BCD-to-segment decode with invalid-code indication, and a 1 Hz blinking separator dot on the minutes-units digit.
- Runs on the same 1 kHz system clock as the stopwatch core.

Parameters:
- DWELL_CYC, 1, clock cycles each digit is driven (≥1); 1 gives 250 Hz frame refresh at 1 kHz.
- BLINK_HALF, 500, clock cycles per half-period of the separator dot (on/off); 500 gives 1 Hz.

Ports:
- CLK  in  1  system clock, 1 kHz.
- RESET  in  1  synchronous, active-high reset.
- MIN_S10  in  4  minutes tens, BCD.
- MIN_S1  in  4  minutes units, BCD.
- SEC_S10  in  4  seconds tens, BCD.
- SEC_S1  in  4  seconds units, BCD.
- SEG  out  8  {dp,g,f,e,d,c,b,a}, active-high.
- COM  out  4  digit enable, one-hot, active-high; COM[0]=SEC_S1 … COM[3]=MIN_S10.
- FRAME  out  1  one-cycle pulse on the cycle the snapshot is taken.

Behaviour:
- Reset: one clock, synchronous, active-high. The only reset input is RESET, sampled on posedge CLK.
- Reset values: SEG=8'h00, COM=4'b0000, FRAME=0, idx=0, dwell=0, blink counter=0, dot=0, snapshot=all zero, first=1.
- Scan counters:
  - dwell increments each cycle. At DWELL_CYC-1 it wraps to 0 and idx increments mod 4.
  - Order is idx 0→1→2→3→0 (SEC_S1, SEC_S10, MIN_S1, MIN_S10).
- Snapshot:
  - All four inputs are captured into internal registers on the edge where idx advances 3→0, and on the first edge after RESET deasserts (first=1, then cleared).
  - FRAME=1 on exactly those edges.
  - Input changes mid-frame are not displayed until the next frame.
- Outputs are registered with 1-cycle latency from (idx, snapshot). COM=one-hot(idx) and SEG=decode(snap[idx]) change together. No cycle has two COM bits set.
- Decode:
  - 0–9: standard patterns, e.g. 0=7'h3F, 1=7'h06, 8=7'h7F, 9=7'h6F over {g..a}.
  - Codes 10–15: show a dash (g only, 7'h40).
- Separator dot:
  - The blink counter counts 0..BLINK_HALF-1. On wrap, dot toggles.
  - SEG[7]=dot only while idx=2 (MIN_S1); otherwise SEG[7]=0.
  - The blink counter is free-running and independent of the scan.
- RESET mid-frame: every register returns to its reset value on that edge. The outputs are blank for the reset cycle(s), and the scan restarts at idx 0 with a fresh snapshot.
- DWELL_CYC=1 is legal: idx advances every cycle. Wrap arithmetic uses counter widths of $clog2 of the parameter, with a minimum of 1 bit.

Optional Feature:
- Macro: SEG7_LZ_BLANK_EN.
- Defined: leading-zero blanking. If snap MIN_S10==0, digit 3 shows SEG=8'h00 (COM still asserted). If additionally snap MIN_S1==0, digit 2's segments are blanked, but the dot is still driven.
- Undefined: all digits are always decoded, so 00:00 shows four zeros.

Decomposition:
- Shared package seg7_pkg:
  - segment pattern constants SEG_0..SEG_9 and SEG_DASH, SEG_BLANK;
  - digit index constants DIG_SEC1=0, DIG_SEC10=1, DIG_MIN1=2, DIG_MIN10=3.
- One sub-module, bcd_to_seg7: purely combinational 4-bit to 7-bit decoder, instantiated once on the muxed digit.
- Scan, snapshot and blink logic stay in the top block.

Test Plan:
- Reset then run, digits 1,2,3,4 (MIN_S10..SEC_S1), DWELL_CYC=1 → COM sequence 0001,0010,0100,1000 repeating, each 1 cycle. SEG{g..a} sequence 7'h66,7'h4F,7'h5B,7'h06. FRAME pulses every 4 cycles.
- Change SEC_S1 from 4 to 5 while idx=1 → digit 0 shows 4 until the next FRAME, then 7'h6D.
- SEC_S10=4'hC → digit 1 segments 7'h40 (dash).
- Run 2000 cycles → SEG[7] asserted only with COM=0100. Dot toggles every 500 cycles, giving 2 full on/off periods.
- Assert RESET for 1 cycle while COM=0100 → next outputs SEG=0, COM=0. The cycle after deassert shows COM=0001 and FRAME=1.
- With SEG7_LZ_BLANK_EN, digits 0,0,0,7 → digits 3 and 2 show SEG{g..a}=0 (dot still blinks on digit 2), digit 1 shows 7'h3F, digit 0 shows 7'h07. Without the macro → 7'h3F,7'h3F,7'h3F,7'h07.
